// File: rtl/prog_loader.sv
// prog_loader: byte-to-word sequencer sitting between uart_rx and the
// instruction memory. A load starts with a 4-byte word count N and is followed
// by N 4-byte instruction words. Each completed word is written with a single
// imem_we pulse. Words past the end of memory are consumed but not written.
module prog_loader #(
  parameter int ADDR_W  = 15,
  parameter bit BYTE_BE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              ovf_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LEN  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Memory capacity in words, widened so a full 32-bit count compares unsigned
  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  logic [1:0]      state;
  logic [1:0]      byte_cnt;
  logic [31:0]     shift_reg;
  logic [31:0]     shift_next;
  logic [31:0]     n_rem;
  logic [ADDR_W:0] wr_idx;
  logic            last;

  // Shift the incoming byte in from the side chosen by the byte order
  always_comb begin
    shift_next = shift_reg;
    if (BYTE_BE) shift_next = {shift_reg[23:0], rx_data};
    else         shift_next = {rx_data, shift_reg[31:8]};
  end

  assign busy = (state == LEN) || (state == DATA);

  // Load sequencer: count phase, data phase, write strobes and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      shift_reg  <= 32'd0;
      n_rem      <= 32'd0;
      wr_idx     <= '0;
      last       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      load_done  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LEN;
            byte_cnt  <= 2'd0;
            shift_reg <= 32'd0;
            imem_addr <= '0;
            wr_idx    <= '0;
            last      <= 1'b0;
            load_done <= 1'b0;
            ovf_err   <= 1'b0;
          end
        end
        LEN: begin
          if (rx_valid) begin
            shift_reg <= shift_next;
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              n_rem <= shift_next;
              if (shift_next == 32'd0) begin
                state     <= DONE;
                load_done <= 1'b1;
              end else begin
                state <= DATA;
              end
              if ({1'b0, shift_next} > CAP) ovf_err <= 1'b1;
            end
          end
        end
        DATA: begin
          // The cycle after the final word's write strobe closes the load;
          // any byte seen here already belongs to the runtime input path.
          if (last) begin
            state     <= DONE;
            load_done <= 1'b1;
            last      <= 1'b0;
          end else if (rx_valid) begin
            shift_reg <= shift_next;
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (!wr_idx[ADDR_W]) begin
                imem_we    <= 1'b1;
                imem_wdata <= shift_next;
                imem_addr  <= wr_idx[ADDR_W-1:0];
                wr_idx     <= wr_idx + (ADDR_W+1)'(1);
              end
              n_rem <= n_rem - 32'd1;
              if (n_rem == 32'd1) last <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven check of the default-size loader, plus hand
// sequences for overflow (ADDR_W=2 instance), mid-load reset and start-while-busy.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;

  logic        imem_we;
  logic [14:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, load_done, ovf_err;

  logic        imem_we2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic        busy2, load_done2, ovf_err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .load_done(load_done), .ovf_err(ovf_err)
  );

  prog_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .load_done(load_done2), .ovf_err(ovf_err2)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d, logic we,
                              logic [31:0] a, logic [31:0] wd, logic b,
                              logic dn, logic o);
    vec_t t;
    t.rst = r; t.start = s; t.valid = v; t.data = d; t.we = we;
    t.addr = a; t.wdata = wd; t.busy = b; t.done = dn; t.ovf = o;
    return t;
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
  task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; start = s; rx_valid = v; rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_we"},    {31'd0, imem_we},  32'd0);
    checkOutput({tag, "_addr"},  {17'd0, imem_addr}, 32'd0);
    checkOutput({tag, "_wdata"}, imem_wdata,        32'd0);
    checkOutput({tag, "_busy"},  {31'd0, busy},     32'd0);
    checkOutput({tag, "_done"},  {31'd0, load_done}, 32'd0);
    checkOutput({tag, "_ovf"},   {31'd0, ovf_err},  32'd0);
    checkOutput({tag, "_we2"},   {31'd0, imem_we2}, 32'd0);
    checkOutput({tag, "_addr2"}, {30'd0, imem_addr2}, 32'd0);
    checkOutput({tag, "_wdata2"}, imem_wdata2,      32'd0);
    checkOutput({tag, "_busy2"}, {31'd0, busy2},    32'd0);
    checkOutput({tag, "_done2"}, {31'd0, load_done2}, 32'd0);
    checkOutput({tag, "_ovf2"},  {31'd0, ovf_err2}, 32'd0);
  endtask

  initial begin
    logic [31:0] words[5];
    logic [31:0] w;
    int          wr_count;

    // Two-word load, back-to-back bytes, DONE ignoring rx, restart, zero count
    vecs.push_back(mk(1,0,0,8'h00, 0,0,32'h0,        0,0,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'h02, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'hDE, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'hAD, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'hBE, 0,0,32'h0,        1,0,0));
    vecs.push_back(mk(0,0,1,8'hEF, 1,0,32'hDEADBEEF, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h01, 0,0,32'hDEADBEEF, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h23, 0,0,32'hDEADBEEF, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h45, 0,0,32'hDEADBEEF, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h67, 1,1,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,1,32'h01234567, 0,1,0));
    vecs.push_back(mk(0,0,1,8'h99, 0,1,32'h01234567, 0,1,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h02, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h11, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h22, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h33, 0,0,32'h01234567, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h44, 1,0,32'h11223344, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h55, 0,0,32'h11223344, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h66, 0,0,32'h11223344, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h77, 0,0,32'h11223344, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h88, 1,1,32'h55667788, 1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,1,32'h55667788, 0,1,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,0,32'h55667788, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h55667788, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h55667788, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h55667788, 1,0,0));
    vecs.push_back(mk(0,0,1,8'h00, 0,0,32'h55667788, 0,1,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,32'h55667788, 0,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("v%0d_we", i),    {31'd0, imem_we},   {31'd0, vecs[i].we});
      checkOutput($sformatf("v%0d_addr", i),  {17'd0, imem_addr}, vecs[i].addr);
      checkOutput($sformatf("v%0d_wdata", i), imem_wdata,         vecs[i].wdata);
      checkOutput($sformatf("v%0d_busy", i),  {31'd0, busy},      {31'd0, vecs[i].busy});
      checkOutput($sformatf("v%0d_done", i),  {31'd0, load_done}, {31'd0, vecs[i].done});
      checkOutput($sformatf("v%0d_ovf", i),   {31'd0, ovf_err},   {31'd0, vecs[i].ovf});
    end

    // Overflow: count of 5 into a 4-word memory (dut2); dut has room for all 5
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h05);
    checkOutput("ovf_set2",   {31'd0, ovf_err2}, 32'd1);
    checkOutput("ovf_busy2",  {31'd0, busy2},    32'd1);
    checkOutput("ovf_clear1", {31'd0, ovf_err},  32'd0);
    for (int i = 0; i < 5; i++) words[i] = 32'hA1B2C300 + 32'(i * 17);
    wr_count = 0;
    for (int i = 0; i < 5; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        sendByte(w[31:24]);
        w = w << 8;
        if (imem_we2) begin
          checkOutput($sformatf("ovf_addr_w%0d", wr_count), {30'd0, imem_addr2}, 32'(wr_count));
          checkOutput($sformatf("ovf_data_w%0d", wr_count), imem_wdata2, words[wr_count]);
          wr_count++;
        end
      end
    end
    checkOutput("ovf_no5th_we",  {31'd0, imem_we2}, 32'd0);
    checkOutput("ovf_wr_count",  32'(wr_count),     32'd4);
    checkOutput("ovf_done_early", {31'd0, load_done2}, 32'd0);
    checkOutput("full_we5",      {31'd0, imem_we},  32'd1);
    checkOutput("full_addr5",    {17'd0, imem_addr}, 32'd4);
    checkOutput("full_data5",    imem_wdata,        words[4]);
    idle();
    checkOutput("ovf_done2",   {31'd0, load_done2}, 32'd1);
    checkOutput("ovf_idle2",   {31'd0, busy2},      32'd0);
    checkOutput("ovf_sticky2", {31'd0, ovf_err2},   32'd1);
    checkOutput("ovf_last_addr2", {30'd0, imem_addr2}, 32'd3);

    // Reset after two data bytes abandons the load
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hAA); sendByte(8'hBB);
    checkOutput("mid_busy2", {31'd0, busy2}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkAllZero("rst");
    begin
      logic [7:0] tail[8];
      tail = '{8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 8; i++) begin
        sendByte(tail[i]);
        checkOutput($sformatf("post_rst_we_%0d", i),  {30'd0, imem_we, imem_we2}, 32'd0);
        checkOutput($sformatf("post_rst_busy_%0d", i), {30'd0, busy, busy2},      32'd0);
      end
    end

    // Start while busy is ignored; start in DONE restarts from addr 0
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h12); sendByte(8'h34);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("sb_busy", {31'd0, busy}, 32'd1);
    sendByte(8'h56);
    sendByte(8'h78);
    checkOutput("sb_we",    {31'd0, imem_we},   32'd1);
    checkOutput("sb_addr",  {17'd0, imem_addr}, 32'd0);
    checkOutput("sb_wdata", imem_wdata,         32'h12345678);
    idle();
    checkOutput("sb_done", {31'd0, load_done}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("rs_done_clr", {31'd0, load_done}, 32'd0);
    checkOutput("rs_busy",     {31'd0, busy},      32'd1);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h9A); sendByte(8'hBC); sendByte(8'hDE); sendByte(8'hF0);
    checkOutput("rs_we",    {31'd0, imem_we},   32'd1);
    checkOutput("rs_addr",  {17'd0, imem_addr}, 32'd0);
    checkOutput("rs_wdata", imem_wdata,         32'h9ABCDEF0);
    idle();
    checkOutput("rs_done", {31'd0, load_done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
